// File: rtl/edge_toggle_gen.sv
// Toggle-mask player: queued {mask, hold} entries are XORed into a level register and held hold+1 cycles.
// Optional macro EDGE_MON_EN adds the mon_edge loopback output (out_level ^ previous out_level, registered).
module edge_toggle_gen #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLD_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WIDTH-1:0]  s_mask,
  input  logic [HOLD_W-1:0] s_hold,
  input  logic              load_en,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  out_level,
  output logic              busy,
`ifdef EDGE_MON_EN
  output logic              done,
  output logic [WIDTH-1:0]  mon_edge
`else
  output logic              done
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]       PTR_ONE = (AW+1)'(1);
  localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  level_q, level_d;
  logic              done_q, done_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  logic [WIDTH-1:0]  mask_mem [FIFO_DEPTH];
  logic [HOLD_W-1:0] hold_mem [FIFO_DEPTH];

  logic empty, full, push, pop;

  // Extra MSB on the pointers separates full (MSBs differ) from empty (equal).
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign s_ready = !full;
  assign push    = s_valid && !full;

  assign out_level = level_q;
  assign done      = done_q;
  assign busy      = (state_q == HOLD) || !empty;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty)       pop     = 1'b1;
        else if (load_en) level_d = load_val;
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      level_d = level_q ^ mask_mem[rd_ptr_q[AW-1:0]];
      cnt_d   = hold_mem[rd_ptr_q[AW-1:0]];
      state_d = HOLD;
    end
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage needs no reset: the pointers define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mask_mem[wr_ptr_q[AW-1:0]] <= s_mask;
      hold_mem[wr_ptr_q[AW-1:0]] <= s_hold;
    end
  end

`ifdef EDGE_MON_EN
  logic [WIDTH-1:0] level_prev_q, mon_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_prev_q <= '0;
      mon_q        <= '0;
    end else begin
      level_prev_q <= level_q;
      mon_q        <= level_q ^ level_prev_q;
    end
  end

  assign mon_edge = mon_q;
`endif

endmodule
